ultrasound_echo_model: RTL and testbench
========================================

# ultrasound_echo_model

Responder-side model of an HC-SR04-style ultrasonic ranging sensor. It accepts the trigger pulse that a ranging driver issues and answers with an echo pulse whose width encodes a programmed distance, at 58 us per cm. It is used in simulation benches and for hardware-in-the-loop bring-up, replacing the physical sensor in front of the ranging driver, so that driver can be checked with exact, repeatable distances.

## Interface
Parameters:
- CLKS_PER_US, 100: clk cycles per microsecond (100 MHz clk).
- MIN_TRIG_US, 10: minimum trig high width accepted.
- ECHO_DELAY_US, 500: gap between trig falling and echo rising (models the 8-cycle burst).
- US_PER_CM, 58: echo microseconds per cm.
- MAX_CM, 400: largest in-range distance.
- TIMEOUT_US, 38000: echo width for no-object or out-of-range.
- HOLDOFF_US, 100: dead time after echo falls.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- enable, in, 1: accept new triggers when 1.
- trig, in, 1: trigger from the ranging driver; asynchronous to clk.
- distance, in, 9: emulated target distance in cm, unsigned.
- echo, out, 1: echo pulse to the ranging driver; registered.
- busy, out, 1: high from echo-delay start until holdoff ends.
- trig_short, out, 1: one-cycle pulse when a trigger is rejected for being too short.

## Operation
- trig passes through a 2-FF synchronizer, giving trig_s. Edge detection uses trig_s and its previous value.
- A phase counter counts clk cycles and is cleared on every state entry. Compare widths are ≥22 bits: TIMEOUT_US*CLKS_PER_US = 3.8M.
- States:
  - IDLE: echo=0, busy=0. On a trig_s rising edge with enable=1, go to TRIG_HI. A rising edge while enable=0 is ignored.
  - TRIG_HI: count cycles while trig_s=1; the count saturates at MIN_TRIG_US*CLKS_PER_US.
    - On trig_s falling with count ≥ MIN_TRIG_US*CLKS_PER_US: latch distance into dist_q and go to DELAY.
    - Otherwise pulse trig_short for 1 cycle and return to IDLE.
  - DELAY: busy=1. After ECHO_DELAY_US*CLKS_PER_US cycles, set echo=1 and go to ECHO.
  - ECHO: echo=1 for exactly W*CLKS_PER_US cycles, then echo=0 and go to HOLDOFF.
  - HOLDOFF: busy=1, echo=0. After HOLDOFF_US*CLKS_PER_US cycles, go to IDLE.
- Echo width W:
  - W = dist_q*US_PER_CM when 1 ≤ dist_q ≤ MAX_CM. The maximum product is 23200, so a 15-bit product suffices.
  - W = TIMEOUT_US when dist_q = 0 or dist_q > MAX_CM.
- enable is sampled only in IDLE. Deasserting it mid-measurement does not abort the measurement.
- distance is sampled only at the accepting trig fall. Later changes do not affect the current echo.
- trig edges in DELAY/ECHO/HOLDOFF are ignored. After HOLDOFF, a new rising edge is required; a trig already high on return to IDLE is not accepted until it goes low and then high again.

## Timing
- Reset values: echo=0, busy=0, trig_short=0, state IDLE, counters 0, synchronizer flops 0, dist_q=0. Reset acts immediately, including mid-echo.
- Edge 0 is the first clk edge at which synchronizer stage 1 samples trig low.
  - The FSM leaves TRIG_HI at edge 2.
  - busy rises at edge 2.
  - echo rises at edge 2 + ECHO_DELAY_US*CLKS_PER_US.
- Accepted trig: a pulse of ≥ MIN_TRIG_US*CLKS_PER_US clk cycles is always accepted; one cycle shorter is always rejected. The synchronizer delays both edges equally, so the measured width is exact.
- echo high width is exact: W*CLKS_PER_US cycles, no ±1 tick error.
- busy falls HOLDOFF_US*CLKS_PER_US cycles after echo falls.
- trig_short is asserted on the cycle after the rejecting falling edge is seen on trig_s (edge 3 relative to edge 0 above).

## Test plan
- trig high 1000 cycles, distance=100 → echo rises 50002 cycles after edge 0 and stays high 580000 cycles. busy falls 10000 cycles after echo falls. trig_short stays 0.
- trig high 999 cycles → trig_short pulses one cycle at edge 3. echo and busy stay 0.
- distance=0, then separately distance=450 → echo width 3800000 cycles in each case. distance=400 → 2320000 cycles; distance=1 → 5800 cycles.
- distance changed from 100 to 5 during ECHO → width still 580000 cycles. Three extra trig pulses during ECHO/HOLDOFF → no second echo. A trig issued after busy falls produces a normal echo.
- rst pulsed mid-ECHO → echo and busy go 0 immediately, without waiting for a clk edge. trig held high across reset release → no response until trig goes low and then high again.
- enable=0 with a valid 1000-cycle trig → no echo. enable dropped to 0 during DELAY → echo still completes with the correct width.

Source files
------------

// File: rtl/ultrasound_echo_model.sv
`default_nettype none
// ============================================================================
// Module : ultrasound_echo_model
// Brief  : HC-SR04-style responder. Answers a trigger pulse with an echo
//          pulse whose width encodes the programmed distance.
// Rev    : 1.0 - initial release
// ============================================================================
module ultrasound_echo_model #(
    parameter int unsigned CLKS_PER_US   = 100,
    parameter int unsigned MIN_TRIG_US   = 10,
    parameter int unsigned ECHO_DELAY_US = 500,
    parameter int unsigned US_PER_CM     = 58,
    parameter int unsigned MAX_CM        = 400,
    parameter int unsigned TIMEOUT_US    = 38000,
    parameter int unsigned HOLDOFF_US    = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       trig_i,
    input  logic [8:0] distance_i,
    output logic       echo_o,
    output logic       busy_o,
    output logic       trig_short_o
);

    localparam int unsigned c_min_trig_cyc = MIN_TRIG_US * CLKS_PER_US;
    localparam int unsigned c_delay_cyc    = ECHO_DELAY_US * CLKS_PER_US;
    localparam int unsigned c_hold_cyc     = HOLDOFF_US * CLKS_PER_US;
    localparam int unsigned c_range_us     = MAX_CM * US_PER_CM;
    localparam int unsigned c_echo_max_us  = (c_range_us > TIMEOUT_US) ? c_range_us : TIMEOUT_US;
    localparam int unsigned c_echo_max_cyc = c_echo_max_us * CLKS_PER_US;
    localparam int unsigned c_long_a       = (c_echo_max_cyc > c_delay_cyc) ? c_echo_max_cyc : c_delay_cyc;
    localparam int unsigned c_long_b       = (c_hold_cyc > c_min_trig_cyc) ? c_hold_cyc : c_min_trig_cyc;
    localparam int unsigned c_longest      = (c_long_a > c_long_b) ? c_long_a : c_long_b;
    localparam int unsigned c_cnt_nat      = $clog2(c_longest + 1);
    localparam int unsigned c_cnt_w        = (c_cnt_nat < 22) ? 22 : c_cnt_nat;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG_HI = 3'd1,
        S_DELAY   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    logic               sync1_q;
    logic               sync2_q;
    logic               trig_prev_q;
    logic [1:0]         fill_q;
    logic               armed_q;
    state_t             state_q;
    logic [c_cnt_w-1:0] phase_q;
    logic [8:0]         dist_q;
    logic               echo_q;
    logic               busy_q;
    logic               short_pend_q;
    logic               trig_short_q;

    logic               trig_rise;
    logic               trig_fall;
    logic [31:0]        echo_us;
    logic [c_cnt_w-1:0] echo_last;

    // The reset value of the synchronizer looks like a low trig; only arm the
    // rising-edge detector once a genuinely sampled low has reached trig_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            trig_prev_q <= 1'b0;
            fill_q      <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            sync1_q     <= trig_i;
            sync2_q     <= sync1_q;
            trig_prev_q <= sync2_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            if ((fill_q == 2'd2) && !sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign trig_rise = armed_q & sync2_q & ~trig_prev_q;
    assign trig_fall = trig_prev_q & ~sync2_q;

    always_comb begin
        if ((dist_q == 9'd0) || (32'(dist_q) > MAX_CM)) begin
            echo_us = TIMEOUT_US;
        end else begin
            echo_us = 32'(dist_q) * US_PER_CM;
        end
        echo_last = c_cnt_w'(echo_us * CLKS_PER_US - 32'd1);
    end

    // The rising-edge cycle is not counted in TRIG_HI, so a high time of
    // exactly c_min_trig_cyc leaves phase_q at c_min_trig_cyc - 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            dist_q       <= 9'd0;
            echo_q       <= 1'b0;
            busy_q       <= 1'b0;
            short_pend_q <= 1'b0;
            trig_short_q <= 1'b0;
        end else begin
            trig_short_q <= short_pend_q;
            short_pend_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    echo_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (trig_rise && enable_i) begin
                        state_q <= S_TRIG_HI;
                        phase_q <= '0;
                    end
                end
                S_TRIG_HI: begin
                    if (trig_fall) begin
                        phase_q <= '0;
                        if (phase_q >= c_cnt_w'(c_min_trig_cyc - 1)) begin
                            dist_q  <= distance_i;
                            busy_q  <= 1'b1;
                            state_q <= S_DELAY;
                        end else begin
                            short_pend_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end
                    end else if (sync2_q && (phase_q < c_cnt_w'(c_min_trig_cyc))) begin
                        phase_q <= phase_q + c_cnt_w'(1);
                    end
                end
                S_DELAY: begin
                    if (phase_q == c_cnt_w'(c_delay_cyc - 1)) begin
                        echo_q  <= 1'b1;
                        phase_q <= '0;
                        state_q <= S_ECHO;
                    end else begin
                        phase_q <= phase_q + c_cnt_w'(1);
                    end
                end
                S_ECHO: begin
                    if (phase_q == echo_last) begin
                        echo_q  <= 1'b0;
                        phase_q <= '0;
                        state_q <= S_HOLDOFF;
                    end else begin
                        phase_q <= phase_q + c_cnt_w'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (phase_q == c_cnt_w'(c_hold_cyc - 1)) begin
                        busy_q  <= 1'b0;
                        phase_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        phase_q <= phase_q + c_cnt_w'(1);
                    end
                end
                default: begin
                    echo_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    phase_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign echo_o       = echo_q;
    assign busy_o       = busy_q;
    assign trig_short_o = trig_short_q;

endmodule
`default_nettype wire

// File: tb/tb_ultrasound_echo_model.sv
`default_nettype none
// ============================================================================
// Module : tb_ultrasound_echo_model
// Brief  : Directed bench for ultrasound_echo_model, scaled-down timing.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ultrasound_echo_model;

    localparam int CPU      = 2;
    localparam int MINT     = 10;
    localparam int DLY      = 25;
    localparam int UPC      = 3;
    localparam int MAXC     = 400;
    localparam int TOUT     = 1500;
    localparam int HOLD     = 10;
    localparam int MIN_CYC  = MINT * CPU;
    localparam int DLY_CYC  = DLY * CPU;
    localparam int HOLD_CYC = HOLD * CPU;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       trig = 1'b0;
    logic [8:0] distance = 9'd100;
    logic       echo;
    logic       busy;
    logic       trig_short;

    ultrasound_echo_model #(
        .CLKS_PER_US  (CPU),
        .MIN_TRIG_US  (MINT),
        .ECHO_DELAY_US(DLY),
        .US_PER_CM    (UPC),
        .MAX_CM       (MAXC),
        .TIMEOUT_US   (TOUT),
        .HOLDOFF_US   (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .trig_i      (trig),
        .distance_i  (distance),
        .echo_o      (echo),
        .busy_o      (busy),
        .trig_short_o(trig_short)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int fail_lines = 0;
    int cyc = 0;

    // Model schedule: expected high windows in absolute edge numbers.
    int es = 0, ee = 0, bs = 0, be = 0, sh = -1;
    bit need_low = 1'b0;
    int last_edge0 = 0;

    int run = 0, last_w = 0, last_rise = 0, last_efall = 0, last_bfall = 0;
    int rises = 0, shorts = 0, last_short = 0;
    bit prev_echo = 1'b0, prev_busy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (fail_lines < 40) begin
                fail_lines++;
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
            end
        end
    endtask

    function automatic int echo_cycles(input int d);
        if (d == 0 || d > MAXC) return TOUT * CPU;
        return d * UPC * CPU;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        chk("echo", int'(echo), int'(cyc >= es && cyc < ee));
        chk("busy", int'(busy), int'(cyc >= bs && cyc < be));
        chk("trig_short", int'(trig_short), int'(cyc == sh));
        if (echo && !prev_echo) begin
            last_rise = cyc;
            rises++;
        end
        if (echo) begin
            run++;
        end else if (prev_echo) begin
            last_w     = run;
            run        = 0;
            last_efall = cyc;
        end
        if (!busy && prev_busy) last_bfall = cyc;
        if (trig_short) begin
            shorts++;
            last_short = cyc;
        end
        prev_echo = echo;
        prev_busy = busy;
    end

    task automatic pulse(input int n);
        int r;
        bit acc;
        @(negedge clk);
        trig = 1'b1;
        r    = cyc + 1;
        acc  = enable && !need_low && (r + 2 > be);
        repeat (n) @(negedge clk);
        trig       = 1'b0;
        need_low   = 1'b0;
        last_edge0 = cyc + 1;
        if (acc) begin
            if (n >= MIN_CYC) begin
                bs = last_edge0 + 2;
                es = bs + DLY_CYC;
                ee = es + echo_cycles(int'(distance));
                be = ee + HOLD_CYC;
            end else begin
                sh = last_edge0 + 3;
            end
        end
    endtask

    task automatic settle();
        while (cyc < be + 5) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_echo", int'(echo), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_short", int'(trig_short), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Minimum-width accepted trigger, then one cycle short.
        distance = 9'd100;
        pulse(MIN_CYC);
        settle();
        chk("width_d100", last_w, 600);
        chk("rise_latency", last_rise - last_edge0, 52);
        chk("holdoff", last_bfall - last_efall, 20);

        pulse(MIN_CYC - 1);
        repeat (10) @(negedge clk);
        chk("short_count", shorts, 1);
        chk("short_edge", last_short - last_edge0, 3);
        chk("rises_after_short", rises, 1);

        distance = 9'd0;   pulse(40); settle(); chk("width_d0", last_w, 3000);
        distance = 9'd450; pulse(40); settle(); chk("width_d450", last_w, 3000);
        distance = 9'd400; pulse(40); settle(); chk("width_d400", last_w, 2400);
        distance = 9'd1;   pulse(40); settle(); chk("width_d1", last_w, 6);

        // Distance change and extra triggers while echoing are ignored.
        distance = 9'd100;
        pulse(40);
        while (cyc < es + 10) @(negedge clk);
        distance = 9'd5;
        for (int i = 0; i < 3; i++) begin
            repeat (20) @(negedge clk);
            pulse(30);
        end
        settle();
        chk("width_locked", last_w, 600);
        chk("rises_single", rises, 6);
        pulse(40);
        settle();
        chk("width_d5", last_w, 30);
        chk("rises_after_busy", rises, 7);

        // Asynchronous reset mid-echo, trig held high through release.
        distance = 9'd100;
        pulse(40);
        while (cyc < es + 100) @(negedge clk);
        #2;
        rst = 1'b1;
        es = 0; ee = 0; bs = 0; be = 0; sh = -1;
        #1;
        chk("rst_async_echo", int'(echo), 0);
        chk("rst_async_busy", int'(busy), 0);
        trig = 1'b1;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        need_low = 1'b1;
        repeat (60) @(negedge clk);
        chk("held_trig_ignored", rises, 8);
        trig     = 1'b0;
        need_low = 1'b0;
        repeat (5) @(negedge clk);
        pulse(40);
        settle();
        chk("width_after_rst", last_w, 600);
        chk("rises_after_rst", rises, 9);

        // enable gating.
        enable = 1'b0;
        pulse(40);
        repeat (200) @(negedge clk);
        chk("disabled_no_echo", rises, 9);
        enable = 1'b1;

        distance = 9'd50;
        pulse(40);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        settle();
        chk("width_enable_drop", last_w, 300);
        chk("rises_enable_drop", rises, 10);
        enable = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
